video_out_ctrl: RTL



---
 rtl/video_out_pkg.sv | 16 +
 rtl/video_out_sync.sv | 30 +++
 rtl/video_out_ctrl.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/video_out_pkg.sv
// Shared definitions for the video output frame scheduler: default frame
// geometry, packet size and the scheduler state encoding.
package video_out_pkg;

  localparam int P_WIDTH_DEF     = 640;
  localparam int P_HEIGHT_DEF    = 480;
  localparam int PACK_PIXELS_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ARM    = 2'd1,
    ST_GO     = 2'd2,
    ST_ACTIVE = 2'd3
  } state_e;

endpackage

// File: rtl/video_out_sync.sv
// Two-flop synchroniser for a clk_out-domain level, with one history flop
// providing single-cycle rise/fall events in the clk domain.
module video_out_sync (
  input  logic clk,
  input  logic nRST,
  input  logic async_in,
  output logic rise,
  output logic fall
);

  logic meta;
  logic sync;
  logic hist;

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      meta <= 1'b0;
      sync <= 1'b0;
      hist <= 1'b0;
    end else begin
      meta <= async_in;
      sync <= meta;
      hist <= sync;
    end
  end

  assign rise = sync & ~hist;
  assign fall = ~sync & hist;

endmodule

// File: rtl/video_out_ctrl.sv
// Frame-level scheduler: tracks pixel-FIFO packet occupancy, releases frames to
// the generator once enough packets are buffered and supervises frame/line progress.
module video_out_ctrl
  import video_out_pkg::*;
#(
  parameter int P_WIDTH     = P_WIDTH_DEF,
  parameter int P_HEIGHT    = P_HEIGHT_DEF,
  parameter int PACK_PIXELS = PACK_PIXELS_DEF,
  parameter int FIFO_PACKS  = 512,
  parameter int CNT_W       = 10,
  parameter int GO_TIMEOUT  = 4095
) (
  input  logic             clk,
  input  logic             nRST,
  input  logic             enable,
  input  logic [CNT_W-1:0] start_thresh,
  input  logic             pack_push,
  input  logic             pix_ack,
  input  logic             frame_valid_a,
  input  logic             line_valid_a,
  output logic             frame_go,
  output logic [CNT_W-1:0] fill_packs,
  output logic [9:0]       line_cnt,
  output logic [15:0]      frame_cnt,
  output logic             frame_done,
  output logic             busy,
  output logic             err_overflow,
  output logic             err_underflow,
  output logic             err_short_frame,
  output logic             err_go_timeout,
  input  logic             err_clr
);

  localparam int PIX_W = (PACK_PIXELS > 1) ? $clog2(PACK_PIXELS) : 1;
  localparam int TO_W  = $clog2(GO_TIMEOUT + 1);

  localparam logic [CNT_W-1:0] FULL       = CNT_W'(FIFO_PACKS);
  localparam logic [PIX_W-1:0] PIX_LAST   = PIX_W'(PACK_PIXELS - 1);
  localparam logic [9:0]       HEIGHT     = 10'(P_HEIGHT);
  localparam logic [TO_W-1:0]  TO_LIMIT   = TO_W'(GO_TIMEOUT);
  localparam int               line_packs_unused = P_WIDTH / PACK_PIXELS;

  function automatic logic [9:0] sat_inc10(input logic [9:0] v);
    return (v == 10'h3FF) ? v : v + 10'd1;
  endfunction

  state_e           state;
  logic [PIX_W-1:0] pix_cnt;
  logic [TO_W-1:0]  to_cnt;

  logic fv_rise;
  logic fv_fall;
  logic lv_rise_unused;
  logic lv_fall;

  logic       consume;
  logic       ovf_evt;
  logic       udf_evt;
  logic       to_evt;
  logic       frame_end;
  logic       short_evt;
  logic [9:0] line_next;

  video_out_sync u_fv_sync (
    .clk      (clk),
    .nRST     (nRST),
    .async_in (frame_valid_a),
    .rise     (fv_rise),
    .fall     (fv_fall)
  );

  video_out_sync u_lv_sync (
    .clk      (clk),
    .nRST     (nRST),
    .async_in (line_valid_a),
    .rise     (lv_rise_unused),
    .fall     (lv_fall)
  );

  // A packet leaves the FIFO when the per-packet pixel counter wraps.
  assign consume = pix_ack && (pix_cnt == PIX_LAST);
  assign ovf_evt = pack_push && !consume && (fill_packs == FULL);
  assign udf_evt = consume && !pack_push && (fill_packs == '0);

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      pix_cnt <= '0;
    end else if (pix_ack) begin
      pix_cnt <= pix_cnt + PIX_W'(1);
    end
  end

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      fill_packs <= '0;
    end else if (pack_push && !consume && !ovf_evt) begin
      fill_packs <= fill_packs + CNT_W'(1);
    end else if (consume && !pack_push && !udf_evt) begin
      fill_packs <= fill_packs - CNT_W'(1);
    end
  end

  // The final line of a frame is counted before the frame-end length check.
  assign line_next = (state == ST_ACTIVE && lv_fall) ? sat_inc10(line_cnt) : line_cnt;
  assign frame_end = (state == ST_ACTIVE) && fv_fall;
  assign short_evt = frame_end && (line_next != HEIGHT);
  assign to_evt    = (state == ST_GO) && !fv_rise && (to_cnt == TO_LIMIT);

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      state      <= ST_IDLE;
      to_cnt     <= '0;
      line_cnt   <= '0;
      frame_cnt  <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= frame_end;
      case (state)
        ST_IDLE: begin
          if (enable) state <= ST_ARM;
        end
        ST_ARM: begin
          if (!enable) begin
            state <= ST_IDLE;
          end else if (fill_packs >= start_thresh) begin
            state  <= ST_GO;
            to_cnt <= '0;
          end
        end
        ST_GO: begin
          if (fv_rise) begin
            state    <= ST_ACTIVE;
            line_cnt <= '0;
          end else if (to_evt) begin
            state <= ST_ARM;
          end else begin
            to_cnt <= to_cnt + TO_W'(1);
          end
        end
        ST_ACTIVE: begin
          line_cnt <= line_next;
          if (fv_fall) begin
            frame_cnt <= frame_cnt + 16'd1;
            state     <= enable ? ST_ARM : ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Sticky flags: a new error in the clearing cycle keeps its flag set.
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      err_overflow    <= 1'b0;
      err_underflow   <= 1'b0;
      err_short_frame <= 1'b0;
      err_go_timeout  <= 1'b0;
    end else begin
      err_overflow    <= (err_overflow    && !err_clr) || ovf_evt;
      err_underflow   <= (err_underflow   && !err_clr) || udf_evt;
      err_short_frame <= (err_short_frame && !err_clr) || short_evt;
      err_go_timeout  <= (err_go_timeout  && !err_clr) || to_evt;
    end
  end

  assign frame_go = (state == ST_GO);
  assign busy     = (state != ST_IDLE);

endmodule
